serial_tx4: RTL and testbench
=============================

Name: serial_tx4

Overview:
- Parallel-to-serial frame transmitter. Takes a DATA_W-bit word on a valid/ready handshake and shifts it out on a single line: start bit, LSB-first data, optional even parity, stop bit.
- It is the driving end of the single-wire link whose capture side is built from the group's latch/flip-flop storage cells. It sits between a parallel producer (register, counter, switches) and the serial line.

Parameters:
- DATA_W, 4, data word width in bits (legal: 1..16).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (legal: >=1).
- PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  DATA_W  parallel word to transmit; sampled only on handshake.
- d_valid  input  1  producer has a word on d.
- d_ready  output  1  transmitter can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a frame has completed.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: rst high at a rising edge forces state IDLE, tx=1, busy=0, done=0, d_ready=1 (from the next cycle), and clears the bit counter, cycle counter and shift register.
- Reset has priority over every other event, including a handshake in the same cycle and a frame in progress. Mid-frame reset aborts the frame and tx returns high on the next cycle.
- All outputs are registered or decoded from registered state only. No combinational path from d or d_valid to tx.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0, d_ready=1.
  - Handshake = d_valid & d_ready at a rising edge.
  - On handshake: latch d into the shift register, compute parity = XOR of d, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift_reg[0], held CLKS_PER_BIT cycles per bit. Shift right after each bit.
  - After bit DATA_W-1, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx = parity (even: total count of 1s in data plus parity bit is even), held CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. done=1 during the first IDLE cycle only.
- d_ready=0 in every state except IDLE.
  - d and d_valid are ignored while busy; nothing is queued.
  - d may change freely after the handshake cycle without affecting the frame.
- Timing, with handshake at edge E0:
  - tx low from cycle E0+1.
  - Frame length F = (2 + DATA_W + PARITY_EN) x CLKS_PER_BIT cycles.
  - done is high in cycle E0+F+1.
  - Defaults: F = 28, done at E0+29.
- Back-to-back: the done cycle is also an IDLE cycle with d_ready=1. A handshake there starts the next frame.
  - Minimum handshake-to-handshake spacing is F+1.
  - Line stays high for CLKS_PER_BIT+1 cycles between frames.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; no special casing.
- Cycle counter: width clog2(CLKS_PER_BIT), minimum 1 bit. Bit counter: width clog2(DATA_W), minimum 1 bit.
  - Both counters reload to 0 on every state change; no wrap past terminal count.
- busy=1 from E0+1 through E0+F inclusive.

Test Plan:
- Reset: rst=1 for 3 cycles with d_valid=1, d=4'hF -> tx=1, busy=0, done=0 throughout; d_ready=1 after release; no frame starts during reset.
- Single frame: d=4'b1011, d_valid pulsed 1 cycle at E0 -> tx per 4-cycle slot = 0,1,1,0,1,1(parity),1; busy high for cycles E0+1..E0+28; done high only at E0+29.
- Zero word plus PARITY_EN=0 build: d=4'h0 -> tx slots 0,0,0,0,0,1; F=24; done at E0+25. PARITY_EN=1 build -> parity slot = 0.
- Back-to-back: d_valid held high, d=4'hA then 4'h5 after the first handshake -> second handshake exactly in the done cycle; tx high for exactly 5 cycles between frames; second frame data slots 1,0,1,0, parity 0.
- Reset mid-frame: assert rst during data bit 2 -> tx=1 and busy=0 the next cycle; no done pulse; a following d=4'h3 frame transmits 0,1,1,0,0,0,1 correctly.
- Busy-time stimulus: toggle d and pulse d_valid while busy -> d_ready stays 0, frame bits unchanged, no extra frame after done.

Source files
------------

// File: rtl/serial_tx4.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data,
// optional even parity, stop bit, on a valid/ready input handshake.
module serial_tx4 #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  input  logic              d_valid,
  output logic              d_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
  logic              cyc_end;

  assign cyc_end = (cyc_q == CYC_LAST);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (d_valid) begin
          shift_d = d;
          par_d   = ^d;
          state_d = S_START;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cyc_end) begin
          state_d = S_DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cyc_end) begin
          shift_d = shift_q >> 1;
          cyc_d   = '0;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cyc_end) begin
          state_d = S_STOP;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cyc_end) begin
          state_d = S_IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  // Line level is decoded purely from registered state.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[0];
      S_PARITY: tx = par_q;
      default:  tx = 1'b1;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign d_ready = (state_q == S_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_serial_tx4.sv
// Randomized bench for serial_tx4: two builds driven in parallel and
// compared every cycle against a slot-level frame model.
module tb_serial_tx4;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic       d_valid;
  logic       rdy0, tx0, busy0, done0;
  logic       rdy1, tx1, busy1, done1;

  int n_chk;
  int n_pass;
  int cyc;

  serial_tx4 #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid),
    .d_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
  );

  serial_tx4 #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid),
    .d_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cpb [2] = '{4, 1};
  int         pen [2] = '{1, 0};
  int         pos [2];
  logic [3:0] word[2];

  function automatic int frame_len(input int i);
    return (2 + 4 + pen[i]) * cpb[i];
  endfunction

  function automatic logic in_frame(input int i);
    return (pos[i] >= 1) && (pos[i] <= frame_len(i));
  endfunction

  // Expected line level: which slot of the frame we are in.
  function automatic logic exp_tx(input int i);
    int s;
    if (!in_frame(i)) return 1'b1;
    s = (pos[i] - 1) / cpb[i];
    if (s == 0) return 1'b0;
    if (s <= 4) return word[i][s-1];
    if (pen[i] != 0 && s == 5) return ^word[i];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h",
                  tag, cyc, got, exp);
  endtask

  task automatic model_edge(input int i);
    if (rst) begin
      pos[i] = 0;
    end else if (!in_frame(i) && d_valid) begin
      word[i] = d;
      pos[i]  = 1;
    end else if (in_frame(i)) begin
      pos[i]++;
    end else begin
      pos[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    @(negedge clk);
    chk("tx0",    32'(tx0),   32'(exp_tx(0)));
    chk("busy0",  32'(busy0), 32'(in_frame(0)));
    chk("ready0", 32'(rdy0),  32'(!in_frame(0)));
    chk("done0",  32'(done0), 32'(pos[0] == frame_len(0) + 1));
    chk("tx1",    32'(tx1),   32'(exp_tx(1)));
    chk("busy1",  32'(busy1), 32'(in_frame(1)));
    chk("ready1", 32'(rdy1),  32'(!in_frame(1)));
    chk("done1",  32'(done1), 32'(pos[1] == frame_len(1) + 1));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse(input logic [3:0] w);
    d       = w;
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    cyc     = 0;
    pos     = '{0, 0};
    word    = '{4'h0, 4'h0};
    rst     = 1'b1;
    d       = 4'hF;
    d_valid = 1'b1;
    run(3);
    rst     = 1'b0;
    d_valid = 1'b0;
    run(2);

    pulse(4'b1011);
    run(34);
    pulse(4'h0);
    run(34);

    // Back-to-back with d_valid held high.
    d       = 4'hA;
    d_valid = 1'b1;
    step();
    d = 4'h5;
    run(60);
    d_valid = 1'b0;
    run(34);

    // Reset during data bit 2 of the slow build.
    pulse(4'hA);
    run(12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(2);
    pulse(4'h3);
    run(34);

    // Input churn while busy.
    pulse(4'h9);
    for (int k = 0; k < 30; k++) begin
      d       = 4'($urandom);
      d_valid = 1'($urandom);
      step();
    end
    d_valid = 1'b0;
    run(34);

    for (int k = 0; k < 3000; k++) begin
      d       = 4'($urandom);
      d_valid = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst     = 1'b0;
    d_valid = 1'b0;
    run(34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
